// File: rtl/mandala_scene_sequencer.sv
// Frame-rate and scene-transition controller for the mandala pattern datapath.
// Turns vsync into frame ticks, advances phase, and sequences fade/swap/fade.
module mandala_scene_sequencer #(
    parameter int HOLD_FRAMES = 240,
    parameter int FADE_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        auto_en,
    input  logic        next_btn,
    input  logic [1:0]  speed,
    output logic        frame_tick,
    output logic [7:0]  phase,
    output logic [1:0]  scene,
    output logic [1:0]  brightness,
    output logic [19:0] ring0,
    output logic [19:0] ring1,
    output logic [19:0] ring2,
    output logic [15:0] seed,
    output logic        seed_load,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_FADE_OUT,
        S_SWITCH,
        S_FADE_IN
    } state_e;

    localparam logic [9:0] HOLD_LAST = 10'(HOLD_FRAMES - 1);
    localparam logic [3:0] STEP_LAST = 4'(FADE_STEP - 1);

    // Packed as {ring0, ring1, ring2, seed}.
    function automatic logic [75:0] scene_cfg(input logic [1:0] s);
        logic [75:0] cfg;
        unique case (s)
            2'd0: cfg = {20'd20000, 20'd40000, 20'd60000, 16'hACE1};
            2'd1: cfg = {20'd10000, 20'd30000, 20'd50000, 16'h1D2B};
            2'd2: cfg = {20'd15000, 20'd25000, 20'd45000, 16'h5A5A};
            default: cfg = {20'd30000, 20'd50000, 20'd70000, 16'hC3E7};
        endcase
        return cfg;
    endfunction

    logic vs_meta_q, vs_sync_q, vs_dly_q;
    logic bt_meta_q, bt_sync_q, bt_dly_q;
    logic btn_edge;

    state_e      state_q, state_d;
    logic        frame_tick_q, frame_tick_d;
    logic [7:0]  phase_q, phase_d;
    logic [1:0]  scene_q, scene_d;
    logic [1:0]  bright_q, bright_d;
    logic [19:0] ring0_q, ring0_d;
    logic [19:0] ring1_q, ring1_d;
    logic [19:0] ring2_q, ring2_d;
    logic [15:0] seed_q, seed_d;
    logic        seed_load_q, seed_load_d;
    logic        busy_q, busy_d;
    logic [9:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  step_cnt_q, step_cnt_d;
    logic [7:0]  inc;

    assign btn_edge     = bt_sync_q & ~bt_dly_q;
    assign frame_tick_d = vs_sync_q & ~vs_dly_q;

    always_comb begin
        unique case (speed)
            2'd0: inc = 8'd0;
            2'd1: inc = 8'd1;
            2'd2: inc = 8'd2;
            default: inc = 8'd4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = frame_tick_q ? phase_q + inc : phase_q;
        scene_d     = scene_q;
        bright_d    = bright_q;
        ring0_d     = ring0_q;
        ring1_d     = ring1_q;
        ring2_d     = ring2_q;
        seed_d      = seed_q;
        seed_load_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        step_cnt_d  = step_cnt_q;

        unique case (state_q)
            S_HOLD: begin
                // A button edge alone triggers, so a coincident tick cannot double-fire.
                if (btn_edge ||
                    (frame_tick_q && auto_en && frame_cnt_q == HOLD_LAST)) begin
                    state_d     = S_FADE_OUT;
                    frame_cnt_d = 10'd0;
                    step_cnt_d  = 4'd0;
                end else if (frame_tick_q && auto_en) begin
                    frame_cnt_d = frame_cnt_q + 10'd1;
                end
            end
            S_FADE_OUT: begin
                if (frame_tick_q) begin
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = 4'd0;
                        bright_d   = bright_q - 2'd1;
                        if (bright_q == 2'd1) state_d = S_SWITCH;
                    end else begin
                        step_cnt_d = step_cnt_q + 4'd1;
                    end
                end
            end
            S_SWITCH: begin
                scene_d     = scene_q + 2'd1;
                {ring0_d, ring1_d, ring2_d, seed_d} = scene_cfg(scene_d);
                seed_load_d = 1'b1;
                state_d     = S_FADE_IN;
            end
            default: begin
                if (frame_tick_q) begin
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = 4'd0;
                        bright_d   = bright_q + 2'd1;
                        if (bright_q == 2'd2) begin
                            state_d     = S_HOLD;
                            frame_cnt_d = 10'd0;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 4'd1;
                    end
                end
            end
        endcase

        busy_d = (state_d != S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_meta_q    <= 1'b0;
            vs_sync_q    <= 1'b0;
            vs_dly_q     <= 1'b0;
            bt_meta_q    <= 1'b0;
            bt_sync_q    <= 1'b0;
            bt_dly_q     <= 1'b0;
            state_q      <= S_HOLD;
            frame_tick_q <= 1'b0;
            phase_q      <= 8'd0;
            scene_q      <= 2'd0;
            bright_q     <= 2'd3;
            ring0_q      <= 20'd20000;
            ring1_q      <= 20'd40000;
            ring2_q      <= 20'd60000;
            seed_q       <= 16'hACE1;
            seed_load_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= 10'd0;
            step_cnt_q   <= 4'd0;
        end else begin
            vs_meta_q    <= vsync;
            vs_sync_q    <= vs_meta_q;
            vs_dly_q     <= vs_sync_q;
            bt_meta_q    <= next_btn;
            bt_sync_q    <= bt_meta_q;
            bt_dly_q     <= bt_sync_q;
            state_q      <= state_d;
            frame_tick_q <= frame_tick_d;
            phase_q      <= phase_d;
            scene_q      <= scene_d;
            bright_q     <= bright_d;
            ring0_q      <= ring0_d;
            ring1_q      <= ring1_d;
            ring2_q      <= ring2_d;
            seed_q       <= seed_d;
            seed_load_q  <= seed_load_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

    assign frame_tick = frame_tick_q;
    assign phase      = phase_q;
    assign scene      = scene_q;
    assign brightness = bright_q;
    assign ring0      = ring0_q;
    assign ring1      = ring1_q;
    assign ring2      = ring2_q;
    assign seed       = seed_q;
    assign seed_load  = seed_load_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mandala_scene_sequencer.sv
// Randomized bench for mandala_scene_sequencer with a frame-level reference model.
// Model tracks fade progress as a tick count and derives brightness arithmetically.
module tb_mandala_scene_sequencer;

    localparam int HF = 4;
    localparam int FS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        auto_en = 1'b0;
    logic        next_btn = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        frame_tick;
    logic [7:0]  phase;
    logic [1:0]  scene;
    logic [1:0]  brightness;
    logic [19:0] ring0, ring1, ring2;
    logic [15:0] seed;
    logic        seed_load;
    logic        busy;

    mandala_scene_sequencer #(.HOLD_FRAMES(HF), .FADE_STEP(FS)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .auto_en(auto_en),
        .next_btn(next_btn), .speed(speed), .frame_tick(frame_tick),
        .phase(phase), .scene(scene), .brightness(brightness),
        .ring0(ring0), .ring1(ring1), .ring2(ring2), .seed(seed),
        .seed_load(seed_load), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sl_cnt = 0;
    bit chk_on = 1'b0;

    int R0[4] = '{20000, 10000, 15000, 30000};
    int R1[4] = '{40000, 30000, 25000, 50000};
    int R2[4] = '{60000, 50000, 45000, 70000};
    int SD[4] = '{'hACE1, 'h1D2B, 'h5A5A, 'hC3E7};

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 hold, 1 fading out, 2 swap, 3 fading in.
    int         m_mode, m_t, m_hold, m_scene, m_bright;
    logic [7:0] m_phase;
    bit         m_tick, m_sl, m_busy;
    bit         vp1, vp2, vp3, bp1, bp2, bp3;

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_hold = 0; m_scene = 0; m_bright = 3;
        m_phase = 8'd0; m_tick = 0; m_sl = 0; m_busy = 0;
        vp1 = 0; vp2 = 0; vp3 = 0; bp1 = 0; bp2 = 0; bp3 = 0;
    endtask

    task automatic model_step();
        bit bedge;
        int inc;
        bedge = bp2 && !bp3;
        inc = (speed == 2'd3) ? 4 : int'(speed);
        m_sl = 0;
        case (m_mode)
            0: begin
                if (bedge || (m_tick && auto_en && m_hold == HF - 1)) begin
                    m_mode = 1; m_t = 0; m_hold = 0;
                end else if (m_tick && auto_en) begin
                    m_hold++;
                end
            end
            1: if (m_tick) begin
                m_t++;
                m_bright = 3 - m_t / FS;
                if (m_t == 3 * FS) m_mode = 2;
            end
            2: begin
                m_scene = (m_scene + 1) % 4;
                m_sl = 1; m_mode = 3; m_t = 0;
            end
            default: if (m_tick) begin
                m_t++;
                m_bright = m_t / FS;
                if (m_t == 3 * FS) begin m_mode = 0; m_hold = 0; end
            end
        endcase
        if (m_tick) m_phase = m_phase + 8'(inc);
        m_tick = vp2 && !vp3;
        m_busy = (m_mode != 0);
        vp3 = vp2; vp2 = vp1; vp1 = vsync;
        bp3 = bp2; bp2 = bp1; bp1 = next_btn;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && chk_on)
            chk("cycle",
                96'({frame_tick, phase, scene, brightness, ring0, ring1,
                     ring2, seed, seed_load, busy}),
                96'({m_tick, m_phase, 2'(m_scene), 2'(m_bright),
                     20'(R0[m_scene]), 20'(R1[m_scene]), 20'(R2[m_scene]),
                     16'(SD[m_scene]), m_sl, m_busy}));
        if (rst_n && seed_load) sl_cnt++;
    end

    task automatic frame(input int w, input int g);
        @(negedge clk) vsync = 1'b1;
        repeat (w) @(negedge clk);
        vsync = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++)
            frame($urandom_range(1, 3), $urandom_range(5, 9));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tick"}, 96'(frame_tick), 96'(0));
        chk({tag, "_phase"}, 96'(phase), 96'(0));
        chk({tag, "_scene"}, 96'(scene), 96'(0));
        chk({tag, "_bright"}, 96'(brightness), 96'(3));
        chk({tag, "_rings"}, 96'({ring0, ring1, ring2}),
            96'({20'd20000, 20'd40000, 20'd60000}));
        chk({tag, "_seed"}, 96'(seed), 96'(16'hACE1));
        chk({tag, "_sl_busy"}, 96'({seed_load, busy}), 96'(0));
    endtask

    int out_tab[6] = '{3, 2, 2, 1, 1, 0};
    int in_tab[6]  = '{0, 1, 1, 2, 2, 3};

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset");
        chk_on = 1'b1;

        speed = 2'd2;
        frames(5);
        chk("phase_x2", 96'(phase), 96'(10));
        speed = 2'd3;
        frames(64);
        chk("phase_wrap", 96'(phase), 96'(10));
        speed = 2'd0;
        frames(7);
        chk("phase_frozen", 96'(phase), 96'(10));

        auto_en = 1'b1;
        frames(3);
        chk("auto_hold3", 96'(busy), 96'(0));
        frames(1);
        chk("auto_trig_busy", 96'(busy), 96'(1));
        chk("auto_trig_bright", 96'(brightness), 96'(3));
        for (int k = 0; k < 6; k++) begin
            frames(1);
            chk("fade_out", 96'(brightness), 96'(out_tab[k]));
        end
        chk("sw_scene", 96'(scene), 96'(1));
        chk("sw_rings", 96'({ring0, ring1, ring2}),
            96'({20'd10000, 20'd30000, 20'd50000}));
        chk("sw_seed", 96'(seed), 96'(16'h1D2B));
        chk("sw_pulses", 96'(sl_cnt), 96'(1));
        auto_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("fade_busy", 96'(busy), 96'(1));
            frames(1);
            chk("fade_in", 96'(brightness), 96'(in_tab[k]));
        end
        chk("auto_done", 96'(busy), 96'(0));

        @(negedge clk) next_btn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("btn_2edges", 96'(busy), 96'(0));
        @(posedge clk);
        @(negedge clk);
        chk("btn_3edges", 96'(busy), 96'(1));
        repeat (2) @(negedge clk);
        next_btn = 1'b0;
        frames(6);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk) next_btn = 1'b1;
            repeat (3) @(negedge clk);
            next_btn = 1'b0;
            frames(1);
        end
        chk("manual_scene", 96'(scene), 96'(2));
        chk("manual_done", 96'(busy), 96'(0));
        frames(300);
        chk("idle_scene", 96'(scene), 96'(2));
        chk("idle_busy", 96'(busy), 96'(0));

        speed = 2'd2;
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) next_btn = 1'b1;
        repeat (5) @(negedge clk);
        vsync = 1'b0;
        next_btn = 1'b0;
        repeat (5) @(negedge clk);
        chk("coinc_phase", 96'(phase), 96'(12));
        chk("coinc_busy", 96'(busy), 96'(1));
        chk("coinc_bright", 96'(brightness), 96'(3));
        speed = 2'd0;
        frames(12);
        chk("coinc_scene", 96'(scene), 96'(3));

        @(negedge clk) next_btn = 1'b1;
        repeat (3) @(negedge clk);
        next_btn = 1'b0;
        frames(12);
        chk("wrap_scene", 96'(scene), 96'(0));
        chk("wrap_seed", 96'(seed), 96'(16'hACE1));
        chk("wrap_rings", 96'({ring0, ring1, ring2}),
            96'({20'd20000, 20'd40000, 20'd60000}));
        chk("wrap_pulses", 96'(sl_cnt), 96'(4));

        for (int i = 0; i < 300; i++) begin
            auto_en  = 1'($urandom_range(0, 1));
            speed    = 2'($urandom_range(0, 3));
            next_btn = ($urandom_range(0, 7) == 0);
            frame($urandom_range(1, 3), $urandom_range(1, 7));
        end
        next_btn = 1'b0;

        speed = 2'd1;
        frames(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            auto_en  = 1'($urandom_range(0, 1));
            speed    = 2'($urandom_range(0, 3));
            next_btn = ($urandom_range(0, 5) == 0);
            frame($urandom_range(1, 3), $urandom_range(1, 7));
        end
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
